// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register made of `depth` stages, each holding
// `width` data bits and a valid bit, with ready/valid handshakes on both sides.
// Empty stages always advance, so bubbles close up even when downstream stalls.
// flush_i or reset_i empties every stage and loads `bubble` into its data.
//
// Ports:
//   clk_i       - clock; every state change happens on its rising edge
//   reset_i     - synchronous, active-high reset
//   write_i     - upstream data
//   valid_i     - upstream data valid
//   ready_o     - block accepts write_i this cycle; combinational from ready_i
//   flush_i     - synchronous squash of all stages
//   read_o      - data of the last stage
//   valid_o     - valid bit of the last stage
//   ready_i     - downstream accepts read_o this cycle
//   occupancy_o - number of valid stages, kept as a registered counter
module pipe_stage_reg #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 1,
  parameter logic [width-1:0] bubble = '0,
  localparam int unsigned occ_w = (depth < 1) ? 1 : $clog2(depth + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [width-1:0] write_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  output logic [width-1:0] read_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [occ_w-1:0] occupancy_o
);

  logic [width-1:0] data_q [depth];
  logic [depth-1:0] v_q;
  logic [occ_w-1:0] occ_q;

  logic [depth-1:0] en;
  logic [depth-1:0] in_v;
  logic [width-1:0] in_d [depth];
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance if it is empty or if every stage below it can move.
  // A running OR from the output side avoids a self-referencing vector.
  always_comb begin
    logic run;
    en  = '0;
    run = ready_i;
    for (int k = int'(depth) - 1; k >= 0; k--) begin
      run   = run | ~v_q[k];
      en[k] = run;
    end
  end

  // Value offered to each stage: upstream port for stage 0, else the previous stage.
  always_comb begin
    in_v    = '0;
    in_v[0] = valid_i;
    for (int k = 0; k < int'(depth); k++) begin
      in_d[k] = bubble;
    end
    in_d[0] = write_i;
    for (int k = 1; k < int'(depth); k++) begin
      in_v[k] = v_q[k-1];
      in_d[k] = data_q[k-1];
    end
  end

  assign ready_o     = en[0] & ~flush_i;
  assign in_xfer     = valid_i & ready_o;
  assign out_xfer    = v_q[depth-1] & ready_i;
  assign read_o      = data_q[depth-1];
  assign valid_o     = v_q[depth-1];
  assign occupancy_o = occ_q;

  // Stage registers; an advancing stage with no valid input takes the bubble value.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      v_q <= '0;
      for (int k = 0; k < int'(depth); k++) begin
        data_q[k] <= bubble;
      end
    end else begin
      for (int k = 0; k < int'(depth); k++) begin
        if (en[k]) begin
          v_q[k]    <= in_v[k];
          data_q[k] <= in_v[k] ? in_d[k] : bubble;
        end
      end
    end
  end

  // Occupancy tracks transfers at the two boundaries rather than counting valid bits.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      occ_q <= '0;
    end else begin
      unique case ({in_xfer, out_xfer})
        2'b10:   occ_q <= occ_q + occ_w'(1);
        2'b01:   occ_q <= occ_q - occ_w'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg with width=8, depth=3, bubble=8'hA5.
module tb_pipe_stage_reg;

  localparam int unsigned width = 8;
  localparam int unsigned depth = 3;
  localparam logic [7:0]  bub   = 8'hA5;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] write_i;
  logic       valid_i;
  logic       ready_o;
  logic       flush_i;
  logic [7:0] read_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] occupancy_o;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(.width(width), .depth(depth), .bubble(bub)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .write_i     (write_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .flush_i     (flush_i),
    .read_o      (read_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, sample handshakes just before the edge, step past it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic fl,
                     output logic in_acc, output logic out_acc, output logic [7:0] out_d);
    valid_i = v;
    write_i = d;
    ready_i = rdy;
    flush_i = fl;
    #1;
    in_acc  = v & ready_o;
    out_acc = valid_o & rdy;
    out_d   = read_o;
    @(posedge clk_i);
    #1;
  endtask

  logic       ia, oa;
  logic [7:0] od;
  int         sent, exp_out, idx, lo, hi, occ_exp;
  logic [7:0] exp4 [4];
  logic [7:0] q [$];
  logic       rv, rr, rf;
  logic [7:0] rd;
  logic       exp_rdy;

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; write_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;

    // Reset state and idle
    for (int c = 0; c < 3; c++) begin
      check("idle_read", 32'(read_o), 32'(bub));
      check("idle_valid", 32'(valid_o), 32'd0);
      check("idle_occ", 32'(occupancy_o), 32'd0);
      check("idle_ready", 32'(ready_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, ia, oa, od);
    end

    // Full-rate stream 01..08
    for (int c = 0; c < 12; c++) begin
      cyc(c < 8, 8'(c + 1), 1'b1, 1'b0, ia, oa, od);
      check("t2_acc", 32'(ia), 32'(c < 8));
      check("t2_valid", 32'(valid_o), 32'(c >= 2 && c <= 9));
      check("t2_read", 32'(read_o), (c >= 2 && c <= 9) ? 32'(c - 1) : 32'(bub));
      lo = (c - 2 > 0) ? c - 2 : 0;
      hi = (c < 7) ? c : 7;
      occ_exp = (hi >= lo) ? hi - lo + 1 : 0;
      check("t2_occ", 32'(occupancy_o), 32'(occ_exp));
    end

    // Stall from the second output onward
    sent = 0; exp_out = 1;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 8'(sent + 1), 1'b1, 1'b0, ia, oa, od);
      if (ia) sent++;
      if (oa) begin check("t3_out", 32'(od), 32'(exp_out)); exp_out++; end
    end
    check("t3_sent", 32'(sent), 32'd4);
    check("t3_occ_full", 32'(occupancy_o), 32'd3);
    ready_i = 1'b0; valid_i = 1'b1; write_i = 8'h05;
    #1;
    check("t3_rdy_drop", 32'(ready_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 8'(sent + 1), 1'b0, 1'b0, ia, oa, od);
      check("t3_stall_acc", 32'(ia), 32'd0);
      check("t3_hold", 32'(read_o), 32'h02);
      check("t3_hold_v", 32'(valid_o), 32'd1);
    end
    cyc(1'b1, 8'(sent + 1), 1'b1, 1'b0, ia, oa, od);
    check("t3_passthru", 32'(ia), 32'd1);
    if (ia) sent++;
    if (oa) begin check("t3_out", 32'(od), 32'(exp_out)); exp_out++; end
    for (int c = 0; c < 20 && exp_out < 9; c++) begin
      cyc(sent < 8, 8'(sent + 1), 1'b1, 1'b0, ia, oa, od);
      if (ia) sent++;
      if (oa) begin check("t3_out", 32'(od), 32'(exp_out)); exp_out++; end
    end
    check("t3_all_out", 32'(exp_out), 32'd9);
    check("t3_empty", 32'(occupancy_o), 32'd0);

    // Gappy input under stall: bubbles collapse
    cyc(1'b1, 8'h20, 1'b0, 1'b0, ia, oa, od);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, ia, oa, od);
    cyc(1'b1, 8'h21, 1'b0, 1'b0, ia, oa, od);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, ia, oa, od);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, ia, oa, od);
    check("t4_occ", 32'(occupancy_o), 32'd3);
    check("t4_valid", 32'(valid_o), 32'd1);
    check("t4_read", 32'(read_o), 32'h20);
    valid_i = 1'b1; write_i = 8'h23;
    #1;
    check("t4_full_rdy", 32'(ready_o), 32'd0);
    exp4[0] = 8'h20; exp4[1] = 8'h21; exp4[2] = 8'h22; exp4[3] = 8'h23;
    idx = 0; sent = 0;
    for (int c = 0; c < 15 && idx < 4; c++) begin
      cyc(sent == 0, 8'h23, 1'b1, 1'b0, ia, oa, od);
      if (ia) sent++;
      if (oa) begin check("t4_order", 32'(od), 32'(exp4[idx])); idx++; end
    end
    check("t4_drained", 32'(idx), 32'd4);

    // Flush a full pipe while offering 8'h13
    cyc(1'b1, 8'h10, 1'b0, 1'b0, ia, oa, od);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, ia, oa, od);
    cyc(1'b1, 8'h12, 1'b0, 1'b0, ia, oa, od);
    check("t5_full", 32'(occupancy_o), 32'd3);
    cyc(1'b1, 8'h13, 1'b0, 1'b1, ia, oa, od);
    check("t5_flush_acc", 32'(ia), 32'd0);
    check("t5_valid", 32'(valid_o), 32'd0);
    check("t5_read", 32'(read_o), 32'(bub));
    check("t5_occ", 32'(occupancy_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, ia, oa, od);
      check("t5_no13", 32'(valid_o), 32'd0);
    end

    // Reset together with flush while streaming
    for (int c = 0; c < 4; c++) cyc(1'b1, 8'(8'h30 + c), 1'b1, 1'b0, ia, oa, od);
    reset_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; write_i = 8'h34;
    #1;
    check("t6_rdy_flush", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check("t6_valid", 32'(valid_o), 32'd0);
    check("t6_read", 32'(read_o), 32'(bub));
    check("t6_occ", 32'(occupancy_o), 32'd0);
    check("t6_ready", 32'(ready_o), 32'd1);

    // Random traffic against an in-order queue model
    for (int c = 0; c < 10000; c++) begin
      rv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 63) == 0);
      rd = 8'($urandom);
      valid_i = rv; write_i = rd; ready_i = rr; flush_i = rf;
      #1;
      exp_rdy = !rf && !(q.size() == depth && !rr);
      check("rnd_ready", 32'(ready_o), 32'(exp_rdy));
      if (valid_o) begin
        check("rnd_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) check("rnd_data", 32'(read_o), 32'(q[0]));
      end else begin
        check("rnd_bubble", 32'(read_o), 32'(bub));
      end
      ia = rv & ready_o;
      oa = valid_o & rr;
      @(posedge clk_i);
      #1;
      if (oa && q.size() > 0) void'(q.pop_front());
      if (rf) q.delete();
      else if (ia) q.push_back(rd);
      check("rnd_occ", 32'(occupancy_o), 32'(q.size()));
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, ia, oa, od);
      if (oa) begin
        check("drain_data", 32'(od), 32'(q[0]));
        void'(q.pop_front());
      end
    end
    check("drain_left", 32'(q.size()), 32'd0);
    check("drain_occ", 32'(occupancy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
